// File: rtl/reg_file.sv
// Three-read/one-write architectural register file with a committed-write counter.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  input  logic [AW-1:0]   A3,
  input  logic            WE3,
  input  logic [XLEN-1:0] WD3,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic [AW-1:0]   DbgA,
  output logic [XLEN-1:0] DbgD,
  output logic [31:0]     WrCount
);

  // x0 has no storage; it is hardwired to zero on every read port.
  logic [XLEN-1:0] r_regs [1:NREGS-1];
  logic [31:0]     r_wr_count;
  logic            w_wr_en;

  assign w_wr_en = WE3 && (A3 != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < int'(NREGS); i++) begin
        r_regs[i] <= '0;
      end
      r_wr_count <= '0;
    end else if (w_wr_en) begin
      for (int i = 1; i < int'(NREGS); i++) begin
        if (A3 == AW'(i)) begin
          r_regs[i] <= WD3;
        end
      end
      r_wr_count <= r_wr_count + 32'd1;
    end
  end

  assign WrCount = r_wr_count;

  // Port 0 = RD1, 1 = RD2, 2 = DbgD; all share identical read semantics.
  for (genvar p = 0; p < 3; p++) begin : g_port
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;

    assign w_addr = (p == 0) ? A1 : ((p == 1) ? A2 : DbgA);

    always_comb begin
      w_data = '0;
      if (rst_n) begin
        for (int i = 1; i < int'(NREGS); i++) begin
          if (w_addr == AW'(i)) begin
            w_data = r_regs[i];
          end
        end
`ifdef REG_FILE_BYPASS_EN
        // w_wr_en excludes A3 == 0, so x0 is never forwarded.
        if (w_wr_en && (w_addr == A3)) begin
          w_data = WD3;
        end
`endif
      end
    end
  end

  assign RD1  = g_port[0].w_data;
  assign RD2  = g_port[1].w_data;
  assign DbgD = g_port[2].w_data;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// against an array-based model of the architectural registers and write count.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  A1, A2, A3, DbgA;
  logic        WE3;
  logic [31:0] WD3;
  logic [31:0] RD1, RD2, DbgD, WrCount;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mdl [32];
  logic [31:0] mdl_cnt;

  reg_file dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A1      (A1),
    .A2      (A2),
    .A3      (A3),
    .WE3     (WE3),
    .WD3     (WD3),
    .RD1     (RD1),
    .RD2     (RD2),
    .DbgA    (DbgA),
    .DbgD    (DbgD),
    .WrCount (WrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void mdl_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mdl_cnt = 32'd0;
  endfunction

  // Value a read port should show right now, given the driven write inputs.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 32'd0;
`ifdef REG_FILE_BYPASS_EN
    if (WE3 && A3 != 5'd0 && a == A3) return WD3;
`endif
    return mdl[a];
  endfunction

  // Inputs are already set (1 time unit after an edge); take one edge and update the model.
  task automatic tick();
    @(posedge clk);
    if (rst_n && WE3 && A3 != 5'd0) begin
      mdl[A3] = WD3;
      mdl_cnt = mdl_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic set_wr(input logic we, input logic [4:0] a, input logic [31:0] d);
    WE3 = we; A3 = a; WD3 = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    A1 = 5'd1; A2 = 5'd2; DbgA = 5'd3;
    set_wr(1'b1, 5'd1, 32'h1234_5678);
    mdl_reset();
    tick();
    tick();
    n_cmp++;
    if (RD1 !== 32'd0 || RD2 !== 32'd0 || DbgD !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_reads: RD1=%h RD2=%h DbgD=%h, required all 0", RD1, RD2, DbgD);
    end
    n_cmp++;
    if (WrCount !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_count: WrCount=%h, required 0", WrCount);
    end
    rst_n = 1'b1;
    set_wr(1'b1, 5'd1, 32'hCAFE_0001);
    tick();
    set_wr(1'b0, 5'd0, 32'd0);
    #1;
    n_cmp++;
    if (RD1 !== 32'hCAFE_0001 || WrCount !== 32'd1) begin
      n_fail++;
      $display("FAIL first_write_after_reset: RD1=%h WrCount=%h, required CAFE0001 / 1",
               RD1, WrCount);
    end
  endtask

  task automatic test_x0_write();
    logic [31:0] cnt0;
    cnt0 = mdl_cnt;
    set_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
    A1 = 5'd0; A2 = 5'd0; DbgA = 5'd0;
    #1;
    n_cmp++;
    if (RD1 !== 32'd0 || RD2 !== 32'd0 || DbgD !== 32'd0) begin
      n_fail++;
      $display("FAIL x0_pre_edge: RD1=%h RD2=%h DbgD=%h, required 0", RD1, RD2, DbgD);
    end
    tick();
    set_wr(1'b0, 5'd0, 32'd0);
    #1;
    n_cmp++;
    if (RD1 !== 32'd0 || WrCount !== cnt0) begin
      n_fail++;
      $display("FAIL x0_write: RD1=%h WrCount=%h, required 0 / %h", RD1, WrCount, cnt0);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] cnt0;
    cnt0 = mdl_cnt;
    set_wr(1'b1, 5'd1, 32'h0000_0007);
    tick();
    set_wr(1'b1, 5'd2, 32'hFFFF_FFF9);
    tick();
    set_wr(1'b0, 5'd2, 32'h0);
    A1 = 5'd1; A2 = 5'd2; DbgA = 5'd2;
    #1;
    n_cmp++;
    if (RD1 !== 32'h0000_0007 || RD2 !== 32'hFFFF_FFF9 || DbgD !== 32'hFFFF_FFF9) begin
      n_fail++;
      $display("FAIL write_read: RD1=%h RD2=%h DbgD=%h, required 00000007 FFFFFFF9 FFFFFFF9",
               RD1, RD2, DbgD);
    end
    n_cmp++;
    if (WrCount !== cnt0 + 32'd2) begin
      n_fail++;
      $display("FAIL write_read_count: WrCount=%h, required %h", WrCount, cnt0 + 32'd2);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] pre_exp;
    set_wr(1'b1, 5'd3, 32'h11);
    tick();
    set_wr(1'b1, 5'd3, 32'h22);
    A1 = 5'd3; A2 = 5'd0; DbgA = 5'd3;
`ifdef REG_FILE_BYPASS_EN
    pre_exp = 32'h22;
`else
    pre_exp = 32'h11;
`endif
    #1;
    n_cmp++;
    if (RD1 !== pre_exp || DbgD !== pre_exp || RD2 !== 32'd0) begin
      n_fail++;
      $display("FAIL same_cycle_pre: RD1=%h DbgD=%h RD2=%h, required %h %h 0",
               RD1, DbgD, RD2, pre_exp, pre_exp);
    end
    tick();
    set_wr(1'b0, 5'd0, 32'd0);
    #1;
    n_cmp++;
    if (RD1 !== 32'h22) begin
      n_fail++;
      $display("FAIL same_cycle_post: RD1=%h, required 00000022", RD1);
    end
  endtask

  task automatic test_we_low();
    logic [31:0] cnt0;
    set_wr(1'b1, 5'd4, 32'h4444_0004);
    tick();
    cnt0 = mdl_cnt;
    set_wr(1'b0, 5'd4, 32'h55);
    A1 = 5'd4;
    tick();
    tick();
    n_cmp++;
    if (RD1 !== 32'h4444_0004 || WrCount !== cnt0) begin
      n_fail++;
      $display("FAIL we_low: RD1=%h WrCount=%h, required 44440004 / %h", RD1, WrCount, cnt0);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 300; c++) begin
      A1   = 5'($urandom_range(0, 31));
      A2   = ($urandom_range(0, 3) == 0) ? A1 : 5'($urandom_range(0, 31));
      DbgA = 5'($urandom_range(0, 31));
      set_wr($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom());
      if ($urandom_range(0, 4) == 0) A1 = A3;
      #1;
      n_cmp++;
      if (RD1 !== exp_rd(A1) || RD2 !== exp_rd(A2) || DbgD !== exp_rd(DbgA) ||
          WrCount !== mdl_cnt) begin
        n_fail++;
        if (bad < 5)
          $display("FAIL random[%0d]: RD1=%h RD2=%h DbgD=%h Cnt=%h, required %h %h %h %h",
                   c, RD1, RD2, DbgD, WrCount, exp_rd(A1), exp_rd(A2), exp_rd(DbgA), mdl_cnt);
        bad++;
      end
      tick();
    end
    set_wr(1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_wrap_dbg();
    set_wr(1'b0, 5'd0, 32'd0);
    force dut.r_wr_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_wr_count;
    mdl_cnt = 32'hFFFF_FFFE;
    #1;
    set_wr(1'b1, 5'd31, 32'hA5A5_A5A5);
    tick();
    set_wr(1'b0, 5'd0, 32'd0);
    DbgA = 5'd31;
    #1;
    n_cmp++;
    if (DbgD !== 32'hA5A5_A5A5 || WrCount !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL dbg_read: DbgD=%h WrCount=%h, required A5A5A5A5 / FFFFFFFF", DbgD, WrCount);
    end
    set_wr(1'b1, 5'd30, 32'h3030_3030);
    tick();
    set_wr(1'b0, 5'd0, 32'd0);
    #1;
    n_cmp++;
    if (WrCount !== 32'd0 || WrCount !== mdl_cnt) begin
      n_fail++;
      $display("FAIL count_wrap: WrCount=%h, required 00000000", WrCount);
    end
  endtask

  task automatic test_async_reset();
    set_wr(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    set_wr(1'b0, 5'd0, 32'd0);
    A1 = 5'd5; A2 = 5'd30; DbgA = 5'd5;
    #1;
    n_cmp++;
    if (RD1 !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL pre_async_reset: RD1=%h, required DEADBEEF", RD1);
    end
    #1;
    rst_n = 1'b0;
    mdl_reset();
    #1;
    n_cmp++;
    if (RD1 !== 32'd0 || RD2 !== 32'd0 || DbgD !== 32'd0 || WrCount !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: RD1=%h RD2=%h DbgD=%h WrCount=%h, required all 0",
               RD1, RD2, DbgD, WrCount);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (RD1 !== 32'd0 || RD2 !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset_storage: RD1=%h RD2=%h, required 0", RD1, RD2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    A1 = '0; A2 = '0; A3 = '0; DbgA = '0; WE3 = 1'b0; WD3 = '0;
    mdl_reset();
    #1;
    test_reset();
    test_x0_write();
    test_write_read();
    test_same_cycle();
    test_we_low();
    test_random();
    test_wrap_dbg();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
